// File: rtl/j_pixel_scanner.sv
// rtl/j_pixel_scanner.sv - raster-order pixel index generator with valid/ready handshake
// Walks col fastest then row over a latched width x height frame, one index per transfer.
module j_pixel_scanner #(
    parameter int DIM_W = 13
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             start,
    input  logic             clear,
    input  logic [DIM_W-1:0] img_width,
    input  logic [DIM_W-1:0] img_height,
    input  logic             addr_ready,
    output logic             addr_valid,
    output logic [DIM_W-1:0] col,
    output logic [DIM_W-1:0] row,
    output logic             row_end,
    output logic             frame_end,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [DIM_W-1:0] ONE = DIM_W'(1);

    state_t           state;
    state_t           state_nxt;
    logic [DIM_W-1:0] width_q;
    logic [DIM_W-1:0] height_q;
    logic [DIM_W-1:0] col_q;
    logic [DIM_W-1:0] row_q;
    logic             transfer;
    logic             last_col;
    logic             last_row;
    logic             accept_start;
    logic             empty_frame;

    // width_q/height_q are nonzero whenever SCAN is reachable, so the -1 never wraps there
    assign last_col     = (col_q == width_q - ONE);
    assign last_row     = (row_q == height_q - ONE);
    assign transfer     = (state == SCAN) && addr_ready;
    assign accept_start = (state == IDLE) && start && !clear;
    assign empty_frame  = (img_width == '0) || (img_height == '0);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_nxt = empty_frame ? DONE : SCAN;
                    end
                end
                SCAN: begin
                    if (transfer && last_col && last_row) begin
                        state_nxt = DONE;
                    end
                end
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        addr_valid = (state == SCAN);
        busy       = (state == SCAN);
        done       = (state == DONE);
        row_end    = addr_valid && last_col;
        frame_end  = row_end && last_row;
        col        = col_q;
        row        = row_q;
    end

    // Index datapath: clear wins over start, start over transfers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            width_q  <= '0;
            height_q <= '0;
            col_q    <= '0;
            row_q    <= '0;
        end else if (clear) begin
            col_q <= '0;
            row_q <= '0;
        end else if (accept_start) begin
            width_q  <= img_width;
            height_q <= img_height;
            col_q    <= '0;
            row_q    <= '0;
        end else if (transfer) begin
            if (!last_col) begin
                col_q <= col_q + ONE;
            end else if (!last_row) begin
                col_q <= '0;
                row_q <= row_q + ONE;
            end else begin
                col_q <= '0;
                row_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_j_pixel_scanner.sv
// tb/tb_j_pixel_scanner.sv - scoreboard bench for j_pixel_scanner against a raster-order model
module tb_j_pixel_scanner;

    localparam int DIM_W = 13;

    logic             clk;
    logic             n_rst;
    logic             start;
    logic             clear;
    logic [DIM_W-1:0] img_width;
    logic [DIM_W-1:0] img_height;
    logic             addr_ready;
    logic             addr_valid;
    logic [DIM_W-1:0] col;
    logic [DIM_W-1:0] row;
    logic             row_end;
    logic             frame_end;
    logic             busy;
    logic             done;

    typedef struct {
        int c;
        int r;
        bit re;
        bit fe;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   done_cnt = 0;
    int   exp_done = 0;
    int   rdy_mode = 0;
    int   stall_cnt = 0;
    int   valid_seen = 0;

    j_pixel_scanner #(.DIM_W(DIM_W)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .start      (start),
        .clear      (clear),
        .img_width  (img_width),
        .img_height (img_height),
        .addr_ready (addr_ready),
        .addr_valid (addr_valid),
        .col        (col),
        .row        (row),
        .row_end    (row_end),
        .frame_end  (frame_end),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Ready driver: 0 = always ready, 1 = random, 2 = three-cycle stall at col 1
    initial begin
        addr_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1: addr_ready = ($urandom_range(0, 3) != 0);
                2: begin
                    if (addr_valid && col == 1 && stall_cnt < 3) begin
                        addr_ready = 1'b0;
                        stall_cnt++;
                    end else begin
                        addr_ready = 1'b1;
                    end
                end
                default: addr_ready = 1'b1;
            endcase
        end
    end

    // Monitor: peek the expected index every valid cycle, pop only on a transfer
    always @(negedge clk) begin
        if (n_rst) begin
            if (addr_valid) begin
                valid_seen++;
                if (q.size() == 0) begin
                    chk("unexpected_valid", 1, 0);
                end else begin
                    chk("col", int'(col), q[0].c);
                    chk("row", int'(row), q[0].r);
                    chk("row_end", int'(row_end), int'(q[0].re));
                    chk("frame_end", int'(frame_end), int'(q[0].fe));
                    chk("busy", int'(busy), 1);
                    if (addr_ready) void'(q.pop_front());
                end
            end else begin
                chk("idle_flags", int'({busy, row_end, frame_end}), 0);
            end
            if (done) begin
                done_cnt++;
                chk("done_after_last", q.size(), 0);
            end
        end
    end

    task automatic push_frame(input int w, input int h);
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++)
                q.push_back('{c, r, (c == w - 1), (c == w - 1) && (r == h - 1)});
    endtask

    task automatic pulse_start(input int w, input int h);
        @(posedge clk);
        #1;
        img_width  = DIM_W'(w);
        img_height = DIM_W'(h);
        start      = 1'b1;
        @(posedge clk);
        #1;
        start      = 1'b0;
        img_width  = DIM_W'($urandom);
        img_height = DIM_W'($urandom);
    endtask

    task automatic run_frame(input int w, input int h, input bit inject);
        int budget;
        push_frame(w, h);
        pulse_start(w, h);
        if (inject) begin
            @(posedge clk);
            #1;
            img_width  = DIM_W'(2);
            img_height = DIM_W'(2);
            start      = 1'b1;
            @(posedge clk);
            #1;
            start      = 1'b0;
        end
        exp_done++;
        budget = w * h * 8 + 20;
        while (done_cnt < exp_done && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        chk("frame_done_in_time", int'(budget > 0), 1);
        @(posedge clk);
        @(negedge clk);
        chk("queue_drained", q.size(), 0);
        chk("done_count", done_cnt, exp_done);
        chk("back_to_idle", int'({addr_valid, done}), 0);
    endtask

    initial begin
        int budget;
        int vs;
        n_rst      = 1'b0;
        start      = 1'b0;
        clear      = 1'b0;
        img_width  = '0;
        img_height = '0;
        #1;
        chk("rst_outputs", int'({addr_valid, row_end, frame_end, busy, done}), 0);
        chk("rst_col_row", int'(col) + int'(row), 0);
        repeat (3) @(posedge clk);
        #1;
        n_rst = 1'b1;

        // Basic 3x2 frame with continuous ready
        rdy_mode = 0;
        run_frame(3, 2, 1'b0);

        // 4x1 with a three-cycle stall at (1,0)
        rdy_mode  = 2;
        stall_cnt = 0;
        run_frame(4, 1, 1'b0);
        chk("stall_applied", stall_cnt, 3);

        // Zero-width frame: done without any valid cycle
        rdy_mode = 0;
        vs = valid_seen;
        run_frame(0, 5, 1'b0);
        chk("zero_no_valid", valid_seen - vs, 0);
        vs = valid_seen;
        run_frame(7, 0, 1'b0);
        chk("zero_h_no_valid", valid_seen - vs, 0);

        // Clear at (5,3) of a 10x10 frame
        push_frame(10, 10);
        pulse_start(10, 10);
        budget = 200;
        while (!(addr_valid && col == 5 && row == 3) && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        chk("reached_5_3", int'(budget > 0), 1);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        q.delete();
        chk("clear_idle", int'({addr_valid, busy, done}), 0);
        chk("clear_col_row", int'(col) + int'(row), 0);
        repeat (4) @(posedge clk);
        #1;
        chk("clear_no_done", done_cnt, exp_done);
        run_frame(2, 2, 1'b0);

        // Asynchronous reset mid-frame
        push_frame(6, 6);
        pulse_start(6, 6);
        repeat (8) @(posedge clk);
        #3;
        n_rst = 1'b0;
        #1;
        chk("async_rst_flags", int'({addr_valid, row_end, frame_end, busy, done}), 0);
        chk("async_rst_col_row", int'(col) + int'(row), 0);
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_stays_idle", int'({addr_valid, busy, done}), 0);
        chk("rst_no_done", done_cnt, exp_done);

        // Start pulses during SCAN are ignored
        run_frame(5, 3, 1'b1);

        // Randomized frames with random back-pressure
        rdy_mode = 1;
        for (int i = 0; i < 12; i++) begin
            int w = $urandom_range(1, 9);
            int h = $urandom_range(1, 6);
            run_frame(w, h, (w * h >= 4) && ($urandom_range(0, 1) == 1));
        end

        // Widest row: 8191 transfers, frame_end on col 8190
        rdy_mode = 0;
        vs = valid_seen;
        run_frame(8191, 1, 1'b0);
        chk("wide_transfers", valid_seen - vs, 8191);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
